// File: rtl/hpdcache_pkg.sv
// ============================================================================
// Module   : hpdcache_pkg
// Brief    : Shared types and constants for the HPDcache directory init sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hpdcache_pkg;

   localparam int unsigned HPDCACHE_DIR_NSETS   = 128;
   localparam int unsigned HPDCACHE_DIR_NWAYS   = 4;
   localparam int unsigned HPDCACHE_DIR_ENTRY_W = 32;
   localparam int unsigned HPDCACHE_DIR_SET_W   = $clog2(HPDCACHE_DIR_NSETS);

   typedef logic [HPDCACHE_DIR_SET_W-1:0]   hpdcache_dir_set_t;
   typedef logic [HPDCACHE_DIR_NWAYS-1:0]   hpdcache_way_vector_t;
   typedef logic [HPDCACHE_DIR_ENTRY_W-1:0] hpdcache_dir_entry_t;

   // An all-zero entry is the invalid directory entry.
   localparam hpdcache_dir_entry_t HPDCACHE_DIR_INV_ENTRY = '0;

   typedef enum logic [1:0] {
      DIR_INIT   = 2'd0,
      DIR_IDLE   = 2'd1,
      DIR_FLUSH  = 2'd2,
      DIR_VERIFY = 2'd3
   } hpdcache_dir_init_state_e;

endpackage

`default_nettype wire

// File: rtl/hpdcache_dir_sweep_cnt.sv
// ============================================================================
// Module   : hpdcache_dir_sweep_cnt
// Brief    : Directory set counter with start/last flags, shared by all sweeps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdcache_dir_sweep_cnt #(
   parameter  int unsigned NSETS = 128,
   localparam int unsigned SET_W = $clog2(NSETS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [SET_W-1:0] cnt_o,
   output logic             start_o,
   output logic             last_o
);

   logic [SET_W-1:0] cnt_q;
   logic [SET_W-1:0] cnt_d;

   // NSETS is a power of two, so the natural wrap returns to set 0.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = cnt_q + SET_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o   = cnt_q;
   assign start_o = (cnt_q == '0);
   assign last_o  = (cnt_q == SET_W'(NSETS - 1));

endmodule

`default_nettype wire

// File: rtl/hpdcache_dir_init_seq.sv
// ============================================================================
// Module   : hpdcache_dir_init_seq
// Brief    : Directory init/flush sweeper in front of the HPDcache directory array.
//            Optional readback check enabled by HPDCACHE_DIR_INIT_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdcache_dir_init_seq
   import hpdcache_pkg::*;
#(
   parameter  int unsigned NSETS   = HPDCACHE_DIR_NSETS,
   parameter  int unsigned NWAYS   = HPDCACHE_DIR_NWAYS,
   parameter  int unsigned ENTRY_W = HPDCACHE_DIR_ENTRY_W,
   localparam int unsigned SET_W   = $clog2(NSETS)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [SET_W-1:0]         core_dir_addr_i,
   input  logic [NWAYS-1:0]         core_dir_cs_i,
   input  logic [NWAYS-1:0]         core_dir_we_i,
   input  logic [NWAYS*ENTRY_W-1:0] core_dir_wentry_i,
   output logic                     core_ready_o,
   input  logic                     inv_req_i,
   output logic                     inv_ack_o,
   output logic                     init_done_o,
   output logic                     busy_o,
   output logic [SET_W-1:0]         dir_addr_o,
   output logic [NWAYS-1:0]         dir_cs_o,
   output logic [NWAYS-1:0]         dir_we_o,
   output logic [NWAYS*ENTRY_W-1:0] dir_wentry_o
`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
   ,
   input  logic [NWAYS*ENTRY_W-1:0] dir_rentry_i,
   output logic                     init_err_o
`endif
);

   localparam logic [NWAYS*ENTRY_W-1:0] INV_LINE = {NWAYS{ENTRY_W'(HPDCACHE_DIR_INV_ENTRY)}};

   hpdcache_dir_init_state_e state_q, state_d;
   logic init_done_q, init_done_d;
   logic inv_ack_q, inv_ack_d;
   logic idle_first_q, idle_first_d;

   logic             cnt_en;
   logic [SET_W-1:0] cnt;
   logic             cnt_start;
   logic             cnt_last;
   logic             verify_tail;

   hpdcache_dir_sweep_cnt #(
      .NSETS   (NSETS)
   ) i_sweep_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (cnt_en),
      .cnt_o   (cnt),
      .start_o (cnt_start),
      .last_o  (cnt_last)
   );

`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
   logic rd_vld_q, rd_vld_d;
   logic init_err_q, init_err_d;

   // The counter has wrapped back to 0 while the last read is still in flight.
   assign verify_tail = (state_q == DIR_VERIFY) && cnt_start && rd_vld_q;
   assign init_err_d  = init_err_q | (rd_vld_q & (|dir_rentry_i));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_vld_q   <= 1'b0;
         init_err_q <= 1'b0;
      end else begin
         rd_vld_q   <= rd_vld_d;
         init_err_q <= init_err_d;
      end
   end

   assign init_err_o = init_err_q & ~rst_i;
`else
   logic cnt_start_unused;
   assign cnt_start_unused = cnt_start;
   assign verify_tail      = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= DIR_INIT;
         init_done_q  <= 1'b0;
         inv_ack_q    <= 1'b0;
         idle_first_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_done_q  <= init_done_d;
         inv_ack_q    <= inv_ack_d;
         idle_first_q <= idle_first_d;
      end
   end

   // Next state; the first IDLE cycle after any sweep never accepts a flush.
   always_comb begin
      state_d      = state_q;
      init_done_d  = init_done_q;
      inv_ack_d    = 1'b0;
      idle_first_d = 1'b0;
      cnt_en       = 1'b0;
`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
      rd_vld_d     = 1'b0;
`endif
      case (state_q)
         DIR_INIT: begin
            cnt_en = 1'b1;
            if (cnt_last) begin
`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
               state_d      = DIR_VERIFY;
`else
               state_d      = DIR_IDLE;
               init_done_d  = 1'b1;
               idle_first_d = 1'b1;
`endif
            end
         end
         DIR_FLUSH: begin
            cnt_en = 1'b1;
            if (cnt_last) begin
               state_d      = DIR_IDLE;
               inv_ack_d    = 1'b1;
               idle_first_d = 1'b1;
            end
         end
         DIR_IDLE: begin
            if (inv_req_i && !idle_first_q) begin
               state_d = DIR_FLUSH;
            end
         end
`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
         DIR_VERIFY: begin
            if (verify_tail) begin
               state_d      = DIR_IDLE;
               init_done_d  = 1'b1;
               idle_first_d = 1'b1;
            end else begin
               cnt_en   = 1'b1;
               rd_vld_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d = DIR_INIT;
         end
      endcase
   end

   // Outputs; reset forces the array port quiet regardless of the held state.
   always_comb begin
      core_ready_o = 1'b0;
      busy_o       = 1'b1;
      dir_addr_o   = cnt;
      dir_cs_o     = '0;
      dir_we_o     = '0;
      dir_wentry_o = INV_LINE;
      if (!rst_i) begin
         case (state_q)
            DIR_IDLE: begin
               core_ready_o = 1'b1;
               busy_o       = 1'b0;
               dir_addr_o   = core_dir_addr_i;
               dir_cs_o     = core_dir_cs_i;
               dir_we_o     = core_dir_we_i;
               dir_wentry_o = core_dir_wentry_i;
            end
            DIR_INIT, DIR_FLUSH: begin
               dir_cs_o = '1;
               dir_we_o = '1;
            end
            DIR_VERIFY: begin
               dir_cs_o = verify_tail ? '0 : '1;
            end
            default: ;
         endcase
      end
   end

   assign init_done_o = init_done_q & ~rst_i;
   assign inv_ack_o   = inv_ack_q & ~rst_i;

endmodule

`default_nettype wire

// File: tb/tb_hpdcache_dir_init_seq.sv
// ============================================================================
// Module   : tb_hpdcache_dir_init_seq
// Brief    : Directed self-checking bench, NSETS=8 NWAYS=4 ENTRY_W=32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpdcache_dir_init_seq;

   localparam int unsigned NSETS   = 8;
   localparam int unsigned NWAYS   = 4;
   localparam int unsigned ENTRY_W = 32;
   localparam int unsigned SET_W   = 3;
   localparam int unsigned LINE_W  = NWAYS * ENTRY_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [SET_W-1:0]  core_dir_addr;
   logic [NWAYS-1:0]  core_dir_cs;
   logic [NWAYS-1:0]  core_dir_we;
   logic [LINE_W-1:0] core_dir_wentry;
   logic              core_ready;
   logic              inv_req;
   logic              inv_ack;
   logic              init_done;
   logic              busy;
   logic [SET_W-1:0]  dir_addr;
   logic [NWAYS-1:0]  dir_cs;
   logic [NWAYS-1:0]  dir_we;
   logic [LINE_W-1:0] dir_wentry;
`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
   logic [LINE_W-1:0] dir_rentry;
   logic              init_err;
`endif

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hpdcache_dir_init_seq #(
      .NSETS   (NSETS),
      .NWAYS   (NWAYS),
      .ENTRY_W (ENTRY_W)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .core_dir_addr_i   (core_dir_addr),
      .core_dir_cs_i     (core_dir_cs),
      .core_dir_we_i     (core_dir_we),
      .core_dir_wentry_i (core_dir_wentry),
      .core_ready_o      (core_ready),
      .inv_req_i         (inv_req),
      .inv_ack_o         (inv_ack),
      .init_done_o       (init_done),
      .busy_o            (busy),
      .dir_addr_o        (dir_addr),
      .dir_cs_o          (dir_cs),
      .dir_we_o          (dir_we),
      .dir_wentry_o      (dir_wentry)
`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
      ,
      .dir_rentry_i      (dir_rentry),
      .init_err_o        (init_err)
`endif
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the active edge; checks sit 1 unit later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      #1;
   endtask

   // Entered at the start of sweep cycle 1; leaves at the start of the first IDLE cycle.
   task automatic init_sweep(input bit inject);
      for (int k = 0; k < 8; k++) begin
         sample();
         check("init_addr", dir_addr, k);
         check("init_cs_we", {dir_cs, dir_we}, 8'hFF);
         check("init_wentry", dir_wentry, '0);
         check("init_ready", core_ready, 1'b0);
         check("init_done_low", init_done, 1'b0);
         next_cycle();
      end
`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
      for (int v = 0; v < 9; v++) begin
         dir_rentry = (inject && v == 7) ? {LINE_W{1'b0}} | 128'h10 : '0;
         sample();
         if (v < 8) begin
            check("vfy_addr", dir_addr, v);
            check("vfy_cs_we", {dir_cs, dir_we}, 8'hF0);
         end
         check("vfy_busy", {busy, core_ready, init_done}, 3'b100);
         if (v == 8) check("vfy_err_tail", init_err, inject);
         next_cycle();
      end
      dir_rentry = '0;
`else
      if (inject) check("inject_unsupported", 1'b0, 1'b0 | inject);
`endif
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      next_cycle();
      sample();
      check("rst_cs_we", {dir_cs, dir_we}, 8'h00);
      check("rst_flags", {busy, core_ready, init_done, inv_ack}, 4'b1000);
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      core_dir_addr   = '0;
      core_dir_cs     = '0;
      core_dir_we     = '0;
      core_dir_wentry = '0;
      inv_req         = 1'b0;
`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
      dir_rentry      = '0;
`endif

      // Reset and the post-reset sweep
      reset_dut();
      init_sweep(1'b0);
      sample();
      check("idle_flags", {init_done, core_ready, busy, inv_ack}, 4'b1100);

      // Read-only pass-through in the first IDLE cycle
      core_dir_cs     = 4'b0010;
      core_dir_we     = 4'b0000;
      core_dir_addr   = 3'd5;
      core_dir_wentry = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
      sample();
      check("pt_cs", dir_cs, 4'b0010);
      check("pt_addr", dir_addr, 3'd5);
      check("pt_we", dir_we, 4'b0000);
      check("pt_wentry", dir_wentry, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D);

      // Flush request alongside a forwarded write
      next_cycle();
      core_dir_cs   = 4'h1;
      core_dir_we   = 4'h1;
      core_dir_addr = 3'd3;
      inv_req       = 1'b1;
      sample();
      check("flush_acc_fwd", {core_ready, dir_cs, dir_we, dir_addr}, {1'b1, 4'h1, 4'h1, 3'd3});
      next_cycle();
      core_dir_cs = '0;
      core_dir_we = '0;
      for (int k = 0; k < 8; k++) begin
         sample();
         check("flush_addr", dir_addr, k);
         check("flush_flags", {dir_cs, dir_we, core_ready, busy, inv_ack}, {8'hFF, 3'b010});
         next_cycle();
      end
      sample();
      check("flush_ack", {inv_ack, core_ready, busy}, 3'b110);
      next_cycle();
      inv_req = 1'b0;
      sample();
      check("ack_pulse_end", {inv_ack, busy}, 2'b00);
      next_cycle();
      sample();
      check("no_reflush", {busy, core_ready}, 2'b01);

      // Reset in the middle of a flush
      inv_req = 1'b1;
      next_cycle();
      for (int k = 0; k < 4; k++) next_cycle();
      sample();
      check("flush_set4", {dir_addr, busy}, {3'd4, 1'b1});
      rst = 1'b1;
      sample();
      check("rst_mid_cs", {dir_cs, dir_we, busy, inv_ack}, {8'h00, 2'b10});
      next_cycle();
      rst     = 1'b0;
      inv_req = 1'b0;
      init_sweep(1'b0);
      sample();
      check("rst_mid_done", {init_done, inv_ack, busy}, 3'b100);

      // Flush request held from reset
      inv_req = 1'b1;
      reset_dut();
      init_sweep(1'b0);
      sample();
      check("held_idle1", {init_done, busy, core_ready}, 3'b101);
      next_cycle();
      sample();
      check("held_idle2", {busy, core_ready}, 2'b01);
      next_cycle();
      for (int k = 0; k < 8; k++) begin
         sample();
         check("held_flush_addr", {dir_addr, busy, inv_ack}, {k[2:0], 2'b10});
         next_cycle();
      end
      sample();
      check("held_ack", {inv_ack, busy}, 2'b10);
      next_cycle();
      inv_req = 1'b0;
      sample();
      check("held_no_second", {inv_ack, busy}, 2'b00);
      next_cycle();
      sample();
      check("held_idle_after", {busy, core_ready}, 2'b01);

`ifdef HPDCACHE_DIR_INIT_VERIFY_EN
      // Readback mismatch on set 6
      reset_dut();
      init_sweep(1'b1);
      sample();
      check("vfy_done_err", {init_done, init_err, busy}, 3'b110);
      next_cycle();
      sample();
      check("vfy_err_sticky", init_err, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hpdcache_dir_init_seq.md
Name: hpdcache_dir_init_seq

Overview:
- Sits directly upstream of the HPDcache directory/data memory-array wrapper, on its directory port (address, per-way chip-select, per-way write-enable, per-way write entry).
- After reset, sweeps every directory set and writes all ways to the all-zero (invalid) entry.
- Afterwards, passes controller directory accesses through to the array.
- Also serves full-directory invalidate (flush) requests by repeating the sweep.

Parameters:
- NSETS, 128, number of directory sets; power of two, at least 2.
- NWAYS, 4, number of ways.
- ENTRY_W, 32, directory entry width in bits.
- Derived constant: SET_W = $clog2(NSETS).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- core_dir_addr_i  in  SET_W  controller directory set address.
- core_dir_cs_i  in  NWAYS  controller per-way chip-select.
- core_dir_we_i  in  NWAYS  controller per-way write-enable.
- core_dir_wentry_i  in  NWAYS*ENTRY_W  controller write entries.
- core_ready_o  out  1  controller access is forwarded this cycle.
- inv_req_i  in  1  full-directory invalidate request (level; held until inv_ack_o).
- inv_ack_o  out  1  one-cycle pulse: invalidate complete.
- init_done_o  out  1  first post-reset sweep finished (sticky until reset).
- busy_o  out  1  INIT or FLUSH sweep in progress.
- dir_addr_o  out  SET_W  to array directory address.
- dir_cs_o  out  NWAYS  to array chip-select.
- dir_we_o  out  NWAYS  to array write-enable.
- dir_wentry_o  out  NWAYS*ENTRY_W  to array write entries.

Behaviour:
- Reset values (while rst_i=1 and the cycle after):
  - State INIT, set counter 0.
  - init_done_o=0, inv_ack_o=0, busy_o=1, core_ready_o=0.
  - dir_cs_o=0 and dir_we_o=0 while rst_i=1.
- States:
  - INIT: post-reset sweep.
  - IDLE: pass-through.
  - FLUSH: invalidate sweep.
  - VERIFY: optional feature only.
- INIT/FLUSH, each cycle:
  - dir_addr_o=counter, dir_cs_o=dir_we_o=all ones, dir_wentry_o=0.
  - Counter increments by 1.
- A sweep lasts exactly NSETS cycles, set 0 to NSETS-1. On counter==NSETS-1 the counter wraps to 0 and the next state is IDLE.
- INIT to IDLE: init_done_o=1 from the first IDLE cycle onward.
- FLUSH to IDLE: inv_ack_o=1 for exactly the first IDLE cycle.
- IDLE:
  - core_ready_o=1.
  - dir_* outputs are combinational copies of core_dir_* (zero added latency).
  - busy_o=0.
- Handshake: a controller access is taken only in a cycle with core_ready_o=1. While core_ready_o=0 the controller must hold its request. The block never drops or buffers an access.
- inv_req_i accepted in IDLE:
  - The controller access in that same cycle is still forwarded.
  - FLUSH starts the next cycle.
  - The acceptance cycle is never the inv_ack_o cycle, so a held level request is not re-accepted on its ack cycle.
  - The requester must deassert inv_req_i in the cycle after inv_ack_o. If it is still high, a new flush starts.
- inv_req_i asserted during INIT: held pending, accepted in the second IDLE cycle after INIT completes.
- Reset mid-sweep (INIT or FLUSH): abort, restart INIT from set 0, no inv_ack_o pulse.
- Counter arithmetic: SET_W bits, natural wrap. No comparator beyond ==NSETS-1.

Optional Feature:
- Macro: HPDCACHE_DIR_INIT_VERIFY_EN.
- With the macro, two extra ports:
  - dir_rentry_i  in  NWAYS*ENTRY_W  read data from the array.
  - init_err_o  out  1  sticky readback-mismatch flag; reset value 0.
- After the INIT sweep (not after FLUSH), enter VERIFY:
  - Drive dir_cs_o=all ones, dir_we_o=0, address 0..NSETS-1, one set per cycle.
  - Array read latency is 1 cycle: compare dir_rentry_i to 0 in the cycle after each read.
  - Any nonzero bit sets init_err_o.
- VERIFY lasts NSETS+1 cycles (last compare included). Then go to IDLE and set init_done_o.
- busy_o=1 and core_ready_o=0 during VERIFY.
- Without the macro: no extra ports, no VERIFY state, INIT goes directly to IDLE.

Decomposition:
- hpdcache_pkg holds:
  - dir set-address type sized from SET_W.
  - way-vector type.
  - dir entry type.
  - HPDCACHE_DIR_INV_ENTRY constant (all zero).
  - state enum hpdcache_dir_init_state_e.
- One sub-module is natural: hpdcache_dir_sweep_cnt (counter with start/last outputs), shared by INIT, FLUSH and VERIFY.

Test Plan (NSETS=8, NWAYS=4):
- Reset release -> cycles 1-8: dir_addr_o=0..7, cs=we=4'hF, wentry=0. Cycle 9: init_done_o=1, core_ready_o=1, busy_o=0.
- IDLE, core cs=4'b0010 we=0 addr=5 -> same cycle: dir_cs_o=4'b0010, dir_addr_o=5, dir_we_o=0.
- IDLE, inv_req_i=1 with core cs=4'h1 addr=3 -> core access forwarded that cycle. Next 8 cycles: sweep 0..7 with core_ready_o=0. Then inv_ack_o one-cycle pulse.
- rst_i=1 during FLUSH at set 4 -> no inv_ack_o. After release: sweep restarts at 0, init_done_o=0 until cycle 9.
- inv_req_i held from reset -> INIT completes, no flush in the first IDLE cycle, flush accepted in the second IDLE cycle, inv_ack_o after 8 more cycles. inv_req_i deasserted the cycle after ack -> no second flush.
- HPDCACHE_DIR_INIT_VERIFY_EN: dir_rentry_i nonzero for the set-6 read -> init_err_o=1 after the compare, stays 1. init_done_o rises after 9 VERIFY cycles.
